// File: rtl/axil_blockmem_1p_ctrl.sv
// AXI4-Lite slave in front of a single-port, byte-write-enabled block memory.
// One transaction is in flight at a time. Reads and writes alternate when both are pending.
module axil_blockmem_1p_ctrl #(
  parameter int G_DATAWIDTH     = 32,
  parameter int G_MEMDEPTH      = 1024,
  parameter int G_ADDRWIDTH     = $clog2(G_MEMDEPTH),
  parameter int G_AXI_ADDRWIDTH = 32,
  parameter int G_STRBWIDTH     = G_DATAWIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_axil_awaddr,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  input  logic [G_DATAWIDTH-1:0]     s_axil_wdata,
  input  logic [G_STRBWIDTH-1:0]     s_axil_wstrb,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  output logic [1:0]                 s_axil_bresp,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_axil_araddr,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [G_DATAWIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       mem_ena,
  output logic [G_STRBWIDTH-1:0]     mem_wea,
  output logic [G_ADDRWIDTH-1:0]     mem_addra,
  output logic [G_DATAWIDTH-1:0]     mem_dina,
  input  logic [G_DATAWIDTH-1:0]     mem_douta
);

  localparam int S = $clog2(G_STRBWIDTH);
  localparam logic [G_AXI_ADDRWIDTH:0] BYTE_LIMIT =
    (G_AXI_ADDRWIDTH + 1)'(G_MEMDEPTH * G_STRBWIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [2:0] {IDLE, WR_RESP, RD_WAIT, RD_CAP, RD_RESP} state_t;

  state_t state, state_next;
  logic   last_rd;
  logic   rd_err;
  logic   wr_elig, rd_elig, wr_acc, rd_acc;
  logic   grant_wr, grant_rd;
  logic   awready_d, arready_d;
  logic   aw_ok, ar_ok;

  function automatic logic addr_in_range(input logic [G_AXI_ADDRWIDTH-1:0] addr);
    return ({1'b0, addr} < BYTE_LIMIT);
  endfunction

  function automatic logic [G_ADDRWIDTH-1:0] word_addr(input logic [G_AXI_ADDRWIDTH-1:0] addr);
    return addr[G_ADDRWIDTH+S-1:S];
  endfunction

  assign wr_elig = s_axil_awvalid && s_axil_wvalid;
  assign rd_elig = s_axil_arvalid;
  assign wr_acc  = (state == IDLE) && s_axil_awready && wr_elig;
  assign rd_acc  = (state == IDLE) && s_axil_arready && rd_elig && !wr_acc;
  assign aw_ok   = addr_in_range(s_axil_awaddr);
  assign ar_ok   = addr_in_range(s_axil_araddr);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_acc)      state_next = WR_RESP;
        else if (rd_acc) state_next = RD_WAIT;
      end
      WR_RESP: if (s_axil_bready) state_next = IDLE;
      RD_WAIT: state_next = RD_CAP;
      RD_CAP:  state_next = RD_RESP;
      RD_RESP: if (s_axil_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readies are registered: granted one cycle ahead whenever the FSM will be idle next cycle.
  always_comb begin
    grant_wr  = wr_elig && (!rd_elig || last_rd);
    grant_rd  = rd_elig && !grant_wr;
    awready_d = (state_next == IDLE) && grant_wr;
    arready_d = (state_next == IDLE) && grant_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
      mem_ena        <= 1'b0;
      mem_wea        <= '0;
      mem_addra      <= '0;
      mem_dina       <= '0;
      last_rd        <= 1'b1;
      rd_err         <= 1'b0;
    end else begin
      s_axil_awready <= awready_d;
      s_axil_wready  <= awready_d;
      s_axil_arready <= arready_d;
      mem_ena        <= 1'b0;
      mem_wea        <= '0;
      if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
      if (s_axil_rvalid && s_axil_rready) s_axil_rvalid <= 1'b0;
      if (wr_acc) begin
        last_rd       <= 1'b0;
        mem_ena       <= aw_ok;
        mem_wea       <= aw_ok ? s_axil_wstrb : '0;
        mem_addra     <= word_addr(s_axil_awaddr);
        mem_dina      <= s_axil_wdata;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rd_acc) begin
        last_rd   <= 1'b1;
        mem_ena   <= ar_ok;
        mem_addra <= word_addr(s_axil_araddr);
        rd_err    <= !ar_ok;
      end
      // Memory output is valid in RD_CAP; it is held in rdata for the whole response.
      if (state == RD_CAP) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_err ? '0 : mem_douta;
        s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule
